reg_ram_buffer: RTL

Parametrised staging-register plus single-port RAM buffer, next generation of the lab register/RAM block. It keeps the manual register-load, write and display path. It adds generic width and depth, synchronous registered reads, and an FSM-driven burst engine that fills the RAM from a valid/ready input stream or dumps it to a valid/ready output stream. It sits between the switch/keypad front end and the display or stream consumers.

---
 rtl/reg_ram_buffer_pkg.sv | 21 ++
 rtl/reg_ram_buffer_spram.sv | 58 +++++
 rtl/reg_ram_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reg_ram_buffer_pkg.sv
// Shared types and helpers for reg_ram_buffer: FSM states, burst modes, parity.
package reg_ram_buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_DUMP_RD  = 2'd2,
    S_DUMP_OUT = 2'd3
  } state_e;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Parity helper takes a zero-extended word so one function serves any DATA_W.
  localparam int PAR_MAX_W = 64;

  function automatic logic f_even_par(input logic [PAR_MAX_W-1:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/reg_ram_buffer_spram.sv
// Single-port synchronous RAM, registered read-first output with read enable.
// REG_RAM_BUFFER_PARITY_EN widens each word by one stored even-parity bit.
module spram_sync
  import reg_ram_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_q,
  output logic              o_par_err
);

`ifdef REG_RAM_BUFFER_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
  logic [MEM_W-1:0] w_wword;
  assign w_wword = {f_even_par(PAR_MAX_W'(i_wdata)), i_wdata};
`else
  localparam int MEM_W = DATA_W;
  logic [MEM_W-1:0] w_wword;
  assign w_wword = i_wdata;
`endif

  logic [MEM_W-1:0]  r_mem [2**ADDR_W];
  logic [MEM_W-1:0]  w_rd;
  logic [DATA_W-1:0] r_q;

  assign w_rd = r_mem[i_addr];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= w_wword;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)    r_q <= '0;
    else if (i_re) r_q <= w_rd[DATA_W-1:0];
  end

`ifdef REG_RAM_BUFFER_PARITY_EN
  logic r_perr;
  always_ff @(posedge i_clk) begin
    if (!i_rst)    r_perr <= 1'b0;
    else if (i_re) r_perr <= f_even_par(PAR_MAX_W'(w_rd[DATA_W-1:0])) != w_rd[DATA_W];
  end
  assign o_par_err = r_perr;
`else
  assign o_par_err = 1'b0;
`endif

  assign o_q = r_q;

endmodule

// File: rtl/reg_ram_buffer.sv
// Staging register + single-port RAM with manual access and a fill/dump burst FSM.
// Optional stored parity: define REG_RAM_BUFFER_PARITY_EN.
module reg_ram_buffer
  import reg_ram_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_save_data,
  input  logic              i_write_en,
  input  logic              i_show_reg,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic [ADDR_W-1:0] i_len_in,
  input  logic [DATA_W-1:0] i_d_in,
  input  logic              i_burst_start,
  input  logic              i_burst_mode,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_par_err
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_data_reg;
  logic              r_done, w_done_nxt;

  logic              w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;
  logic              w_par_err;
  logic              w_in_ready, w_out_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = r_ptr;
    w_ram_wdata = i_d_in;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Manual write and a burst start may share a cycle; both take effect.
        w_ram_addr  = i_addr_in;
        w_ram_we    = i_write_en;
        w_ram_wdata = r_data_reg;
        w_ram_re    = 1'b1;
        if (i_burst_start) begin
          w_state_nxt = (i_burst_mode == MODE_FILL) ? S_FILL : S_DUMP_RD;
          w_ptr_nxt   = i_addr_in;
          w_cnt_nxt   = i_len_in;
        end
      end
      S_FILL: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_ram_we = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      S_DUMP_RD: begin
        w_ram_re    = 1'b1;
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        // Read enable is off here, so ram_q holds steady under backpressure.
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
            w_state_nxt = S_DUMP_RD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_data_reg <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (i_save_data) r_data_reg <= i_d_in;
    end
  end

  spram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_ram_we),
    .i_re     (w_ram_re),
    .i_addr   (w_ram_addr),
    .i_wdata  (w_ram_wdata),
    .o_q      (w_ram_q),
    .o_par_err(w_par_err)
  );

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = w_out_valid ? w_ram_q : '0;
  assign o_d_out     = i_show_reg ? w_ram_q : r_data_reg;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_par_err   = w_par_err;

endmodule
